// File: rtl/dynamixel_sync_write.sv
// Serializes one Dynamixel 2.0 SYNC WRITE packet (IDs 1-4, CRC-16/0x8005) as 8N1 UART.
// Optional: define DYNAMIXEL_SYNC_WRITE_GUARD_EN to hold a driven idle for 2 bit times before release.
module dynamixel_sync_write #(
  parameter int unsigned clocks_per_bit = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        send,
  input  logic [15:0] address,
  input  logic [15:0] data_len,
  input  logic [31:0] value1,
  input  logic [31:0] value2,
  input  logic [31:0] value3,
  input  logic [31:0] value4,
  output logic        sending,
  output logic        pin
);

  localparam int unsigned CYC_W = $clog2(2 * clocks_per_bit) + 1;
  localparam int unsigned IDX_W = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_GUARD
  } state_t;

  state_t              state_q, state_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic [2:0]          bit_q, bit_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [1:0]          servo_q, servo_d;
  logic [2:0]          pos_q, pos_d;
  logic [7:0]          shift_q, shift_d;
  logic [15:0]         crc_q, crc_d;
  logic [15:0]         addr_q, addr_d;
  logic [15:0]         len_q, len_d;
  logic [3:0][31:0]    val_q, val_d;
  logic                sending_q, sending_d;
  logic                pin_q, pin_d;

  logic [IDX_W-1:0]    last_idx;
  logic [IDX_W-1:0]    nidx;
  logic [1:0]          nservo;
  logic [2:0]          npos;
  logic [7:0]          nbyte;
  logic [15:0]         pkt_len;
  logic                bit_end;

  assign sending = sending_q;
  assign pin     = pin_q;

  // One CRC-16 update (poly 0x8005, MSB first) with a whole byte.
  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ 16'h8005) : (c << 1);
    end
    return c;
  endfunction

  assign bit_end  = (cyc_q == CYC_W'(clocks_per_bit - 1));
  assign last_idx = 6'd17 + {1'b0, len_q[2:0], 2'b00};
  assign pkt_len  = 16'd11 + {11'd0, len_q[2:0], 2'b00};

  // Counters of the byte that follows the current one, and that byte's value.
  always_comb begin
    nidx   = idx_q + 6'd1;
    nservo = servo_q;
    npos   = pos_q;
    if (idx_q < 6'd12) begin
      nservo = 2'd0;
      npos   = 3'd0;
    end else if (pos_q == len_q[2:0]) begin
      nservo = servo_q + 2'd1;
      npos   = 3'd0;
    end else begin
      npos   = pos_q + 3'd1;
    end

    nbyte = 8'h00;
    case (nidx)
      6'd0, 6'd1: nbyte = 8'hFF;
      6'd2:       nbyte = 8'hFD;
      6'd3:       nbyte = 8'h00;
      6'd4:       nbyte = 8'hFE;
      6'd5:       nbyte = pkt_len[7:0];
      6'd6:       nbyte = pkt_len[15:8];
      6'd7:       nbyte = 8'h83;
      6'd8:       nbyte = addr_q[7:0];
      6'd9:       nbyte = addr_q[15:8];
      6'd10:      nbyte = len_q[7:0];
      6'd11:      nbyte = len_q[15:8];
      default: begin
        if (nidx == last_idx - 6'd1) begin
          nbyte = crc_q[7:0];
        end else if (nidx == last_idx) begin
          nbyte = crc_q[15:8];
        end else begin
          case (npos)
            3'd0:    nbyte = 8'd1 + {6'd0, nservo};
            3'd1:    nbyte = val_q[nservo][7:0];
            3'd2:    nbyte = val_q[nservo][15:8];
            3'd3:    nbyte = val_q[nservo][23:16];
            default: nbyte = val_q[nservo][31:24];
          endcase
        end
      end
    endcase
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    bit_d     = bit_q;
    idx_d     = idx_q;
    servo_d   = servo_q;
    pos_d     = pos_q;
    shift_d   = shift_q;
    crc_d     = crc_q;
    addr_d    = addr_q;
    len_d     = len_q;
    val_d     = val_q;
    sending_d = sending_q;
    pin_d     = pin_q;

    case (state_q)
      S_IDLE: begin
        if (send && (data_len != 16'd0) && (data_len <= 16'd4)) begin
          addr_d    = address;
          len_d     = data_len;
          val_d     = {value4, value3, value2, value1};
          state_d   = S_START;
          cyc_d     = '0;
          idx_d     = '0;
          servo_d   = 2'd0;
          pos_d     = 3'd0;
          shift_d   = 8'hFF;
          crc_d     = crc_step(16'h0000, 8'hFF);
          sending_d = 1'b1;
          pin_d     = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          cyc_d   = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
          pin_d   = shift_q[0];
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cyc_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            pin_d   = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            pin_d   = shift_q[1];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cyc_d = '0;
          if (idx_q == last_idx) begin
`ifdef DYNAMIXEL_SYNC_WRITE_GUARD_EN
            state_d = S_GUARD;
`else
            state_d   = S_IDLE;
            sending_d = 1'b0;
`endif
          end else begin
            state_d = S_START;
            idx_d   = nidx;
            servo_d = nservo;
            pos_d   = npos;
            shift_d = nbyte;
            pin_d   = 1'b0;
            // CRC covers everything up to the last data byte, not the CRC itself.
            if (nidx < last_idx - 6'd1) begin
              crc_d = crc_step(crc_q, nbyte);
            end
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_GUARD: begin
        if (cyc_q == CYC_W'(2 * clocks_per_bit - 1)) begin
          cyc_d     = '0;
          state_d   = S_IDLE;
          sending_d = 1'b0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      default: begin
        state_d   = S_IDLE;
        sending_d = 1'b0;
        pin_d     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cyc_q     <= '0;
      bit_q     <= 3'd0;
      idx_q     <= '0;
      servo_q   <= 2'd0;
      pos_q     <= 3'd0;
      shift_q   <= 8'h00;
      crc_q     <= 16'h0000;
      addr_q    <= 16'h0000;
      len_q     <= 16'h0000;
      val_q     <= '0;
      sending_q <= 1'b0;
      pin_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      bit_q     <= bit_d;
      idx_q     <= idx_d;
      servo_q   <= servo_d;
      pos_q     <= pos_d;
      shift_q   <= shift_d;
      crc_q     <= crc_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      val_q     <= val_d;
      sending_q <= sending_d;
      pin_q     <= pin_d;
    end
  end

endmodule

// File: tb/tb_dynamixel_sync_write.sv
// Bench for dynamixel_sync_write: decodes the UART line and compares against a byte-list packet model.
module tb_dynamixel_sync_write;

  localparam int CPB   = 3;
  localparam int LIMIT = 1500;
`ifdef DYNAMIXEL_SYNC_WRITE_GUARD_EN
  localparam int GUARD_CYC = 2 * CPB;
`else
  localparam int GUARD_CYC = 0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        send;
  logic [15:0] address;
  logic [15:0] data_len;
  logic [31:0] value1, value2, value3, value4;
  logic        sending;
  logic        pin;

  int n_checks = 0;
  int n_fail   = 0;

  logic        samp [0:LIMIT-1];
  int          width;
  int unsigned exp_q[$];

  dynamixel_sync_write #(.clocks_per_bit(CPB)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .send    (send),
    .address (address),
    .data_len(data_len),
    .value1  (value1),
    .value2  (value2),
    .value3  (value3),
    .value4  (value4),
    .sending (sending),
    .pin     (pin)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Packet as a plain byte list, then a textbook bitwise CRC over it.
  task automatic build_expected(input int unsigned a, input int unsigned n,
                                input int unsigned v1, input int unsigned v2,
                                input int unsigned v3, input int unsigned v4);
    int unsigned len, crc;
    int unsigned v[4];
    v[0] = v1; v[1] = v2; v[2] = v3; v[3] = v4;
    len = 7 + 4 * (1 + n);
    exp_q.delete();
    exp_q.push_back(8'hFF); exp_q.push_back(8'hFF); exp_q.push_back(8'hFD);
    exp_q.push_back(8'h00); exp_q.push_back(8'hFE);
    exp_q.push_back(len % 256); exp_q.push_back(len / 256); exp_q.push_back(8'h83);
    exp_q.push_back(a % 256); exp_q.push_back(a / 256);
    exp_q.push_back(n % 256); exp_q.push_back(n / 256);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(k + 1);
      for (int j = 0; j < int'(n); j++) exp_q.push_back((v[k] >> (8 * j)) % 256);
    end
    crc = 0;
    foreach (exp_q[i]) begin
      crc = crc ^ (exp_q[i] << 8);
      for (int b = 0; b < 8; b++) begin
        if ((crc & 32'h8000) != 0) crc = ((crc << 1) ^ 32'h8005) & 32'hFFFF;
        else                       crc = (crc << 1) & 32'hFFFF;
      end
    end
    exp_q.push_back(crc % 256);
    exp_q.push_back(crc / 256);
  endtask

  task automatic start_send(input logic [15:0] a, input logic [15:0] n,
                            input logic [31:0] v1, input logic [31:0] v2,
                            input logic [31:0] v3, input logic [31:0] v4);
    @(negedge clock);
    address = a; data_len = n;
    value1 = v1; value2 = v2; value3 = v3; value4 = v4;
    send = 1'b1;
    @(posedge clock);
    #1;
    send = 1'b0;
    check_eq("first_cycle_sending", 32'(sending), 32'd1);
    check_eq("first_cycle_pin", 32'(pin), 32'd0);
  endtask

  // Record pin every cycle while sending is high; optionally re-pulse send with new inputs.
  task automatic capture(input int poke_at);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < LIMIT) begin
      if (sending !== 1'b1) begin
        done = 1'b1;
      end else begin
        samp[n] = pin;
        n++;
        if (n == poke_at) begin
          send     = 1'b1;
          address  = 16'($urandom);
          data_len = 16'($urandom_range(1, 4));
          value1   = $urandom; value2 = $urandom; value3 = $urandom; value4 = $urandom;
        end else begin
          send = 1'b0;
        end
        @(posedge clock);
        #1;
      end
    end
    send  = 1'b0;
    width = n;
    check_eq("capture_bound", 32'(done), 32'd1);
  endtask

  function automatic logic [7:0] decode_byte(input int b);
    logic [7:0] r;
    int idx;
    r = 8'h00;
    for (int j = 0; j < 8; j++) begin
      idx = (b * 10 + 1 + j) * CPB + CPB / 2;
      r[j] = (idx < LIMIT) ? samp[idx] : 1'bx;
    end
    return r;
  endfunction

  task automatic verify(input string name);
    int nb, bad_frame, gidx;
    bit guard_ok;
    nb = exp_q.size();
    check_eq({name, "_width"}, 32'(width), 32'(nb * 10 * CPB + GUARD_CYC));
    bad_frame = 0;
    for (int b = 0; b < nb; b++) begin
      gidx = (b * 10) * CPB + CPB / 2;
      if (gidx + 9 * CPB >= LIMIT || samp[gidx] !== 1'b0 || samp[gidx + 9 * CPB] !== 1'b1)
        bad_frame++;
      check_eq($sformatf("%s_byte%0d", name, b), 32'(decode_byte(b)), exp_q[b]);
    end
    check_eq({name, "_framing"}, 32'(bad_frame), 32'd0);
`ifdef DYNAMIXEL_SYNC_WRITE_GUARD_EN
    guard_ok = 1'b1;
    for (int i = nb * 10 * CPB; i < width && i < LIMIT; i++)
      if (samp[i] !== 1'b1) guard_ok = 1'b0;
    check_eq({name, "_guard_pin"}, 32'(guard_ok), 32'd1);
`else
    guard_ok = 1'b1;
`endif
  endtask

  task automatic random_packet(input string name);
    logic [15:0] a, n;
    logic [31:0] v1, v2, v3, v4;
    a  = 16'($urandom);
    n  = 16'($urandom_range(1, 4));
    v1 = $urandom; v2 = $urandom; v3 = $urandom; v4 = $urandom;
    build_expected(a, n, v1, v2, v3, v4);
    start_send(a, n, v1, v2, v3, v4);
    capture(-1);
    verify(name);
  endtask

  task automatic watch_idle(input string name, input int cycles);
    int busy;
    busy = 0;
    repeat (cycles) begin
      @(posedge clock);
      #1;
      if (sending !== 1'b0 || pin !== 1'b1) busy++;
    end
    check_eq(name, 32'(busy), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; send = 1'b0; address = '0; data_len = '0;
    value1 = '0; value2 = '0; value3 = '0; value4 = '0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("reset_sending", 32'(sending), 32'd0);
    check_eq("reset_pin", 32'(pin), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    watch_idle("idle_after_reset", 5);

    // Directed: address 64, N=1, all ones
    build_expected(64, 1, 1, 1, 1, 1);
    start_send(16'd64, 16'd1, 32'd1, 32'd1, 32'd1, 32'd1);
    capture(-1);
    verify("pkt_n1");
    check_eq("pkt_n1_width_abs", 32'(width), 32'(660 + GUARD_CYC));
    check_eq("pkt_n1_len_l", 32'(decode_byte(5)), 32'h0F);

    // Directed: address 0x0074, N=4
    build_expected(16'h0074, 4, 0, 256, 256, 0);
    start_send(16'h0074, 16'd4, 32'd0, 32'd256, 32'd256, 32'd0);
    capture(-1);
    verify("pkt_n4");
    check_eq("pkt_n4_width_abs", 32'(width), 32'(1020 + GUARD_CYC));
    check_eq("pkt_n4_len_l", 32'(decode_byte(5)), 32'h1B);
    check_eq("pkt_n4_v2_b1", 32'(decode_byte(19)), 32'h01);

    for (int i = 0; i < 4; i++) random_packet($sformatf("rand%0d", i));

    // Re-pulse send with different inputs mid-packet
    build_expected(16'h1234, 2, 32'hA1B2C3D4, 32'h11223344, 32'h55667788, 32'h99AABBCC);
    start_send(16'h1234, 16'd2, 32'hA1B2C3D4, 32'h11223344, 32'h55667788, 32'h99AABBCC);
    capture(100);
    verify("resend");
    watch_idle("no_second_packet", 60);

    // Out-of-range lengths are ignored
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      data_len = (k == 0) ? 16'd0 : 16'd5;
      send = 1'b1;
      @(negedge clock);
      send = 1'b0;
      watch_idle($sformatf("bad_len_%0d", k), 40);
    end

    // Asynchronous reset during byte 10, then a clean packet
    start_send(16'h00AA, 16'd3, $urandom, $urandom, $urandom, $urandom);
    repeat (10 * 10 * CPB + 4) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_sending", 32'(sending), 32'd0);
    check_eq("async_rst_pin", 32'(pin), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    watch_idle("idle_after_midrst", 30);
    random_packet("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
